// File: rtl/rtc_port_arbiter_pkg.sv
// rtc_port_arbiter_pkg
//   Shared definitions for the RTC register-port arbiter: RTC register map,
//   arbiter FSM state encoding and requester side identifiers.
package rtc_port_arbiter_pkg;

  // RTC register map (3-bit register address)
  localparam logic [2:0] RTC_CLOCK      = 3'd0;
  localparam logic [2:0] RTC_TIMER      = 3'd1;
  localparam logic [2:0] RTC_STOPWATCH  = 3'd2;
  localparam logic [2:0] RTC_ALARM      = 3'd3;
  localparam logic [2:0] RTC_CKSPEED    = 3'd4;
  localparam logic [2:0] RTC_HACKTIME   = 3'd5;
  localparam logic [2:0] RTC_HACKCNT_HI = 3'd6;
  localparam logic [2:0] RTC_HACKCNT_LO = 3'd7;

  // One RTC access walks IDLE -> ISSUE -> CAPTURE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  // Requester identity: A is the CPU, B is the time-discipline engine
  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

endpackage

// File: rtl/rtc_rr_pick.sv
// rtc_rr_pick
//   Two-way round-robin pick for the RTC port.
//   req_a/req_b     : strobes from requesters A and B
//   lock/owner      : when lock is set only the owner may be granted
//   last_served     : side that won most recently; loses the next tie
//   grant_a/grant_b : at most one high, only for a requesting side
module rtc_rr_pick
  import rtc_port_arbiter_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  logic  lock,
  input  side_e owner,
  input  side_e last_served,
  output logic  grant_a,
  output logic  grant_b
);

  // Lock beats fairness; without a lock a tie goes to the side not served last
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (lock) begin
      if (owner == SIDE_A) begin
        grant_a = req_a;
      end else begin
        grant_b = req_b;
      end
    end else if (req_a && req_b) begin
      if (last_served == SIDE_A) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/rtc_port_arbiter.sv
// rtc_port_arbiter
//   Shares the single RTC register port between requester A (CPU) and
//   requester B (time-discipline engine). Round-robin grant, bus lock while
//   the owner holds cyc (bounded by HOLD_LIMIT when the other side waits),
//   fixed accept-to-ack latency of 3 cycles generated locally.
//   i_clk, i_rst_n             : clock, async active-low reset
//   i_x_cyc/stb/we/addr/data   : requester x bus cycle, strobe, write, address, write data
//   o_x_stall/ack/data         : requester x stall (comb), ack pulse, read data
//   o_rtc_cyc/stb/we/addr/data : RTC register port
//   i_rtc_data                 : RTC registered read data
module rtc_port_arbiter
  import rtc_port_arbiter_pkg::*;
#(
  parameter int HOLD_LIMIT = 16,
  parameter int HW         = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_cyc,
  input  logic        i_a_stb,
  input  logic        i_a_we,
  input  logic [2:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_stall,
  output logic        o_a_ack,
  output logic [31:0] o_a_data,
  input  logic        i_b_cyc,
  input  logic        i_b_stb,
  input  logic        i_b_we,
  input  logic [2:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_stall,
  output logic        o_b_ack,
  output logic [31:0] o_b_data,
  output logic        o_rtc_cyc,
  output logic        o_rtc_stb,
  output logic        o_rtc_we,
  output logic [2:0]  o_rtc_addr,
  output logic [31:0] o_rtc_data,
  input  logic [31:0] i_rtc_data
);

  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);

  arb_state_e     state_r, state_s;
  logic           owner_vld_r;
  side_e          owner_r, last_r, txn_side_r;
  logic           txn_drop_r;
  logic [HW-1:0]  hold_r;

  logic           owner_cyc_s, other_stb_s, owner_hold_s, lock_s;
  logic           grant_a_s, grant_b_s, accept_a_s, accept_b_s, accept_s;
  logic           release_s, owner_change_s, txn_cyc_s;
  side_e          acc_side_s;
  logic           acc_we_s;
  logic [2:0]     acc_addr_s;
  logic [31:0]    acc_data_s;

  // Owner-relative views: is the owner still holding, is the other side waiting
  always_comb begin
    if (owner_r == SIDE_A) begin
      owner_cyc_s = i_a_cyc;
      other_stb_s = i_b_stb;
    end else begin
      owner_cyc_s = i_b_cyc;
      other_stb_s = i_a_stb;
    end
    owner_hold_s = owner_vld_r & owner_cyc_s;
    // Lock breaks once the waiting side has been held off HOLD_LIMIT cycles
    lock_s       = owner_hold_s & (hold_r < HOLD_MAX);
  end

  rtc_rr_pick u_pick (
    .req_a       (i_a_stb),
    .req_b       (i_b_stb),
    .lock        (lock_s),
    .owner       (owner_r),
    .last_served (last_r),
    .grant_a     (grant_a_s),
    .grant_b     (grant_b_s)
  );

  assign accept_a_s = (state_r == ST_IDLE) & grant_a_s;
  assign accept_b_s = (state_r == ST_IDLE) & grant_b_s;
  assign accept_s   = accept_a_s | accept_b_s;
  assign o_a_stall  = i_a_stb & ~accept_a_s;
  assign o_b_stall  = i_b_stb & ~accept_b_s;

  // Request mux for the accepted side, in-flight requester cyc, ownership events
  always_comb begin
    if (accept_b_s) begin
      acc_side_s = SIDE_B;
      acc_we_s   = i_b_we;
      acc_addr_s = i_b_addr;
      acc_data_s = i_b_data;
    end else begin
      acc_side_s = SIDE_A;
      acc_we_s   = i_a_we;
      acc_addr_s = i_a_addr;
      acc_data_s = i_a_data;
    end
    if (txn_side_r == SIDE_A) begin
      txn_cyc_s = i_a_cyc;
    end else begin
      txn_cyc_s = i_b_cyc;
    end
    release_s      = (state_r == ST_IDLE) & owner_vld_r & ~owner_cyc_s;
    owner_change_s = release_s | (accept_s & (~owner_vld_r | (owner_r != acc_side_s)));
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: one transaction occupies three cycles
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE:   state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Ownership, round-robin history and hold-off counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_vld_r <= 1'b0;
      owner_r     <= SIDE_A;
      last_r      <= SIDE_B;
      hold_r      <= {HW{1'b0}};
    end else begin
      if (accept_s) begin
        owner_vld_r <= 1'b1;
        owner_r     <= acc_side_s;
        last_r      <= acc_side_s;
      end else if (release_s) begin
        owner_vld_r <= 1'b0;
        last_r      <= owner_r;
      end
      if (owner_change_s) begin
        hold_r <= {HW{1'b0}};
      end else if (owner_hold_s && other_stb_s && (hold_r < HOLD_MAX)) begin
        hold_r <= hold_r + {{(HW-1){1'b0}}, 1'b1};
      end
    end
  end

  // RTC port drive and requester completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rtc_cyc  <= 1'b0;
      o_rtc_stb  <= 1'b0;
      o_rtc_we   <= 1'b0;
      o_rtc_addr <= 3'd0;
      o_rtc_data <= 32'd0;
      o_a_ack    <= 1'b0;
      o_b_ack    <= 1'b0;
      o_a_data   <= 32'd0;
      o_b_data   <= 32'd0;
      txn_side_r <= SIDE_A;
      txn_drop_r <= 1'b0;
    end else begin
      o_a_ack <= 1'b0;
      o_b_ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            o_rtc_cyc  <= 1'b1;
            o_rtc_stb  <= 1'b1;
            o_rtc_we   <= acc_we_s;
            o_rtc_addr <= acc_addr_s;
            o_rtc_data <= acc_data_s;
            txn_side_r <= acc_side_s;
            txn_drop_r <= 1'b0;
          end else begin
            // cyc stays asserted only while a lock is still held
            o_rtc_cyc <= owner_hold_s;
          end
        end
        ST_ISSUE: begin
          o_rtc_stb <= 1'b0;
          o_rtc_we  <= 1'b0;
          if (!txn_cyc_s) begin
            txn_drop_r <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          // A requester that abandoned its cycle gets no ack; the RTC access still ran
          if (txn_cyc_s && !txn_drop_r) begin
            if (txn_side_r == SIDE_A) begin
              o_a_ack  <= 1'b1;
              o_a_data <= i_rtc_data;
            end else begin
              o_b_ack  <= 1'b1;
              o_b_data <= i_rtc_data;
            end
          end
          o_rtc_cyc <= txn_cyc_s & ~txn_drop_r;
        end
        default: begin
          o_rtc_stb <= 1'b0;
          o_rtc_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
